unidade_controle_jogada: RTL

- Moore control unit that sequences the memory-game datapath: 4-bit address counter, 16x4 ROM, comparator against `chaves`.
- Detects each new play on `chaves` and registers it.
- Checks the comparator result, advances the counter, and signals a win, a wrong play, or a timeout.
- Sits beside the datapath inside the top-level circuit; the datapath supplies `igual` and `fim_contagem`.

---
 rtl/jogo_pkg.sv | 70 +++++++
 rtl/unidade_controle_jogada_edge_detector.sv | 28 ++
 rtl/unidade_controle_jogada.sv | 122 ++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit.
//   - State codes (also shown on the debug hex display).
//   - Default switch width and timeout length.
//   - Moore output bundle and its decode from the state code.
package jogo_pkg;

  localparam logic [3:0] S_INICIAL     = 4'h0;
  localparam logic [3:0] S_PREPARA     = 4'h1;
  localparam logic [3:0] S_ESPERA      = 4'h2;
  localparam logic [3:0] S_REGISTRA    = 4'h4;
  localparam logic [3:0] S_COMPARA     = 4'h5;
  localparam logic [3:0] S_PROXIMO     = 4'h6;
  localparam logic [3:0] S_FIM_ACERTOU = 4'hA;
  localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] S_FIM_ERROU   = 4'hE;

  // 5000 clocks = 100 us at 50 MHz.
  localparam int CHAVES_W_DEF = 4;
  localparam int TIMEOUT_DEF  = 5000;

  typedef enum logic [3:0] {
    ST_INICIAL     = S_INICIAL,
    ST_PREPARA     = S_PREPARA,
    ST_ESPERA      = S_ESPERA,
    ST_REGISTRA    = S_REGISTRA,
    ST_COMPARA     = S_COMPARA,
    ST_PROXIMO     = S_PROXIMO,
    ST_FIM_ACERTOU = S_FIM_ACERTOU,
    ST_FIM_TIMEOUT = S_FIM_TIMEOUT,
    ST_FIM_ERROU   = S_FIM_ERROU
  } estado_t;

  typedef struct packed {
    logic zera_contador;
    logic conta_contador;
    logic registra;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore outputs for a given state. zera_contador and conta_contador
  // belong to distinct states, so they can never be high together.
  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      ST_PREPARA:     s.zera_contador  = 1'b1;
      ST_REGISTRA:    s.registra       = 1'b1;
      ST_PROXIMO:     s.conta_contador = 1'b1;
      ST_FIM_ACERTOU: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      ST_FIM_ERROU: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.errou   = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogada_edge_detector.sv
// Rising-edge detector.
//   clock  in   system clock
//   reset  in   asynchronous, active-high; clears the history register
//   sinal  in   level to watch
//   pulso  out  high while sinal=1 and it was 0 on the previous clock
// The pulse is combinational on sinal so the caller sees it in the same
// cycle the level rises; it lasts exactly one cycle because prev_q catches
// up on the next edge. Holding sinal high never re-triggers.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sinal;
    end
  end

  assign pulso = sinal & ~prev_q;

endmodule

// File: rtl/unidade_controle_jogada.sv
// Moore control unit for the memory-game datapath (address counter,
// 16x4 ROM, play comparator).
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   iniciar          start/restart request (only honoured in INICIAL/FIM_*)
//   chaves           raw switches; any nonzero value is a play
//   igual            datapath: registered play == ROM[address]
//   fim_contagem     datapath: address counter at its last value
//   zera_contador    clear address counter (PREPARA)
//   conta_contador   advance address counter (PROXIMO)
//   registra         load chaves into the play register (REGISTRA)
//   pronto/acertou/errou/timeout  round result flags
//   db_jogada        debug: play-edge pulse
//   db_estado        debug: current state code
// TIMEOUT must be at least 2.
module unidade_controle_jogada
  import jogo_pkg::*;
#(
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CHAVES_W = CHAVES_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [CHAVES_W-1:0] chaves,
  input  logic                igual,
  input  logic                fim_contagem,
  output logic                zera_contador,
  output logic                conta_contador,
  output logic                registra,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                db_jogada,
  output logic [3:0]          db_estado
);

  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic          jogada_raw;
  logic          jogada_pulse;
  estado_t       estado_q, estado_d;
  saidas_t       saidas_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          fim_tempo;

  assign jogada_raw = |chaves;

  edge_detector u_detector_jogada (
    .clock (clock),
    .reset (reset),
    .sinal (jogada_raw),
    .pulso (jogada_pulse)
  );

  assign fim_tempo = (tcnt_q == TMAX);

  // Idle counter: runs only while waiting for a play, holds at its terminal
  // value instead of wrapping, and restarts from 0 on every entry to ESPERA
  // because every other state clears it.
  always_comb begin
    tcnt_d = '0;
    if (estado_q == ST_ESPERA) begin
      tcnt_d = fim_tempo ? tcnt_q : tcnt_q + TW'(1);
    end
  end

  always_comb begin
    estado_d = ST_INICIAL;
    case (estado_q)
      ST_INICIAL:  estado_d = iniciar ? ST_PREPARA : ST_INICIAL;
      ST_PREPARA:  estado_d = ST_ESPERA;
      // A play seen on the terminal-count cycle takes priority over timeout.
      ST_ESPERA: begin
        if (jogada_pulse)   estado_d = ST_REGISTRA;
        else if (fim_tempo) estado_d = ST_FIM_TIMEOUT;
        else                estado_d = ST_ESPERA;
      end
      ST_REGISTRA: estado_d = ST_COMPARA;
      // igual is valid here: the play register was loaded on the last edge.
      ST_COMPARA: begin
        if (!igual)            estado_d = ST_FIM_ERROU;
        else if (fim_contagem) estado_d = ST_FIM_ACERTOU;
        else                   estado_d = ST_PROXIMO;
      end
      ST_PROXIMO:     estado_d = ST_ESPERA;
      ST_FIM_ACERTOU: estado_d = iniciar ? ST_PREPARA : ST_FIM_ACERTOU;
      ST_FIM_ERROU:   estado_d = iniciar ? ST_PREPARA : ST_FIM_ERROU;
      ST_FIM_TIMEOUT: estado_d = iniciar ? ST_PREPARA : ST_FIM_TIMEOUT;
      default:        estado_d = ST_INICIAL;
    endcase
  end

  // Outputs are registered from the decode of the next state, so they always
  // equal the decode of estado_q (pure Moore) without a combinational path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      saidas_q <= '0;
      tcnt_q   <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= decodifica_saidas(estado_d);
      tcnt_q   <= tcnt_d;
    end
  end

  assign zera_contador  = saidas_q.zera_contador;
  assign conta_contador = saidas_q.conta_contador;
  assign registra       = saidas_q.registra;
  assign pronto         = saidas_q.pronto;
  assign acertou        = saidas_q.acertou;
  assign errou          = saidas_q.errou;
  assign timeout        = saidas_q.timeout;
  assign db_estado      = estado_q;

  // Masked during reset so every output reads 0 while reset is held, even
  // if the switches are already nonzero.
  assign db_jogada = jogada_pulse & ~reset;

endmodule
